// File: rtl/mem_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : mem_traffic_gen
// Description : Per-channel memory traffic generator (COUNT, BYTE_COUNT,
//               RANDOM and HOLD modes) with saturating rising-edge monitors
//               for the DUT's error-detected and error-corrected flags.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_traffic_gen #(
    parameter int NUM_CH = 2,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16,
    parameter int ACT_W  = 4,
    parameter int ERR_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [1:0]               mode,
    input  logic [CNT_W-1:0]         run_cycles,
    input  logic [ACT_W-1:0]         activity,
    input  logic [31:0]              seed,
    output logic [NUM_CH-1:0]        mem_wr,
    output logic [NUM_CH*DATA_W-1:0] mem_data,
    input  logic [NUM_CH-1:0]        err_detected,
    input  logic [NUM_CH-1:0]        err_corrected,
    output logic                     busy,
    output logic                     sync,
    output logic                     done,
    output logic [NUM_CH*ERR_W-1:0]  det_cnt,
    output logic [NUM_CH*ERR_W-1:0]  cor_cnt,
    output logic [NUM_CH-1:0]        err_sticky
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [1:0]       c_MODE_COUNT  = 2'd0;
    localparam logic [1:0]       c_MODE_BYTE   = 2'd1;
    localparam logic [1:0]       c_MODE_RANDOM = 2'd2;
    localparam logic [31:0]      c_GOLDEN      = 32'h9E3779B9;
    localparam logic [31:0]      c_LFSR_TAPS   = 32'h80200003;
    localparam logic [ERR_W-1:0] c_ERR_MAX     = {ERR_W{1'b1}};

    // Replicate a 32-bit word across DATA_W bits (truncating if narrower).
    function automatic logic [DATA_W-1:0] f_rep32(input logic [31:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) r[i] = v[i % 32];
        return r;
    endfunction

    // Replicate one byte across the data word.
    function automatic logic [DATA_W-1:0] f_rep8(input logic [7:0] v);
        logic [DATA_W-1:0] r;
        r = '0;
        for (int i = 0; i < DATA_W; i++) r[i] = v[i % 8];
        return r;
    endfunction

    // One step of the right-shifting Galois LFSR.
    function automatic logic [31:0] f_lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ c_LFSR_TAPS) : (v >> 1);
    endfunction

    state_t             r_state;
    logic [1:0]         r_mode;
    logic [CNT_W-1:0]   r_run_cycles;
    logic [CNT_W-1:0]   r_elapsed;
    logic [ACT_W-1:0]   r_activity;
    logic [7:0]         r_cnt8;
    logic               r_busy;
    logic               r_sync;
    logic               r_done;

    logic               w_start_acc;
    logic [CNT_W-1:0]   w_run_max;
    logic [CNT_W-1:0]   w_elapsed_nxt;
    logic [CNT_W-1:0]   w_sync_thr;
    logic               w_finish;
    logic               w_step;

    // Start is only honoured outside RUN; a zero run length still runs one cycle.
    assign w_start_acc   = start && (r_state != S_RUN);
    assign w_run_max     = (r_run_cycles == '0) ? CNT_W'(1) : r_run_cycles;
    assign w_elapsed_nxt = r_elapsed + CNT_W'(1);
    assign w_sync_thr    = r_run_cycles - (r_run_cycles >> 3);
    assign w_finish      = (r_state == S_RUN) && (w_elapsed_nxt == w_run_max);
    assign w_step        = (r_state == S_RUN) && !w_finish;

    assign busy = r_busy;
    assign sync = r_sync;
    assign done = r_done;

    // Run-control FSM: latches run settings, counts elapsed cycles, flags.
    // The seed is consumed on the start edge by every channel, so no copy is kept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= S_IDLE;
            r_mode       <= '0;
            r_run_cycles <= '0;
            r_activity   <= '0;
            r_elapsed    <= '0;
            r_cnt8       <= '0;
            r_busy       <= 1'b0;
            r_sync       <= 1'b0;
            r_done       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_mode       <= mode;
                        r_run_cycles <= run_cycles;
                        r_activity   <= activity;
                        r_elapsed    <= '0;
                        r_cnt8       <= '0;
                        r_busy       <= 1'b1;
                        r_sync       <= 1'b0;
                        r_done       <= 1'b0;
                    end
                end
                S_RUN: begin
                    r_elapsed <= w_elapsed_nxt;
                    // Registered so sync is visible in the cycle whose elapsed reaches the threshold.
                    if (w_elapsed_nxt >= w_sync_thr) r_sync <= 1'b1;
                    if (w_finish) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else begin
                        r_cnt8 <= r_cnt8 + 8'd1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic [31:0]       w_seed_raw;
        logic [31:0]       w_seed_lfsr;
        logic [31:0]       w_lfsr_nxt;
        logic              w_upd;
        logic              w_det_rise;
        logic              w_cor_rise;
        logic              r_wr;
        logic [DATA_W-1:0] r_data;
        logic [31:0]       r_lfsr;
        logic              r_det_q;
        logic              r_cor_q;
        logic [ERR_W-1:0]  r_det_cnt;
        logic [ERR_W-1:0]  r_cor_cnt;
        logic              r_sticky;

        // COUNT/HOLD use the raw per-channel seed; the LFSR must never be all-zero.
        assign w_seed_raw  = seed ^ (32'(c) * c_GOLDEN);
        assign w_seed_lfsr = (w_seed_raw == 32'd0) ? 32'd1 : w_seed_raw;
        assign w_lfsr_nxt  = f_lfsr_step(r_lfsr);
        assign w_upd       = ((w_lfsr_nxt[31 -: ACT_W] & r_activity) == '0);
        assign w_det_rise  = err_detected[c] & ~r_det_q;
        assign w_cor_rise  = err_corrected[c] & ~r_cor_q;

        // Traffic datapath: load mode init on start, advance each non-final RUN cycle.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_wr   <= 1'b0;
                r_data <= '0;
                r_lfsr <= '0;
            end else if (w_start_acc) begin
                r_lfsr <= w_seed_lfsr;
                case (mode)
                    c_MODE_COUNT: begin
                        r_wr   <= 1'b1;
                        r_data <= f_rep32(w_seed_raw);
                    end
                    c_MODE_BYTE: begin
                        r_wr   <= 1'b1;
                        r_data <= '0;
                    end
                    c_MODE_RANDOM: begin
                        // The loaded LFSR state is presented as the first word.
                        r_wr   <= w_seed_lfsr[0];
                        r_data <= f_rep32(w_seed_lfsr);
                    end
                    default: begin
                        r_wr   <= 1'b0;
                        r_data <= f_rep32(w_seed_raw);
                    end
                endcase
            end else if (w_finish) begin
                // Data stays on the bus after the run; only the strobe drops.
                r_wr <= 1'b0;
            end else if (w_step) begin
                case (r_mode)
                    c_MODE_COUNT:  r_data <= r_data + DATA_W'(1);
                    c_MODE_BYTE:   r_data <= f_rep8(r_cnt8 + 8'd1);
                    c_MODE_RANDOM: begin
                        r_lfsr <= w_lfsr_nxt;
                        if (w_upd) begin
                            r_wr   <= w_lfsr_nxt[0];
                            r_data <= f_rep32(w_lfsr_nxt);
                        end
                    end
                    default: ;
                endcase
            end
        end

        // Error monitors: rising-edge saturating counters, cleared by an accepted start.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_det_q   <= 1'b0;
                r_cor_q   <= 1'b0;
                r_det_cnt <= '0;
                r_cor_cnt <= '0;
                r_sticky  <= 1'b0;
            end else begin
                r_det_q <= err_detected[c];
                r_cor_q <= err_corrected[c];
                if (w_start_acc) begin
                    r_det_cnt <= '0;
                    r_cor_cnt <= '0;
                    r_sticky  <= 1'b0;
                end else begin
                    if (w_det_rise && (r_det_cnt != c_ERR_MAX)) r_det_cnt <= r_det_cnt + ERR_W'(1);
                    if (w_cor_rise && (r_cor_cnt != c_ERR_MAX)) r_cor_cnt <= r_cor_cnt + ERR_W'(1);
                    if (w_det_rise) r_sticky <= 1'b1;
                end
            end
        end

        assign mem_wr[c]                      = r_wr;
        assign mem_data[c*DATA_W +: DATA_W]   = r_data;
        assign det_cnt[c*ERR_W +: ERR_W]      = r_det_cnt;
        assign cor_cnt[c*ERR_W +: ERR_W]      = r_cor_cnt;
        assign err_sticky[c]                  = r_sticky;
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_traffic_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_traffic_gen
// Description : Directed self-checking bench for mem_traffic_gen (2 channels,
//               32-bit data, 8-bit error counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_traffic_gen;

    localparam logic [1:0] c_COUNT  = 2'd0;
    localparam logic [1:0] c_BYTE   = 2'd1;
    localparam logic [1:0] c_RANDOM = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  mode;
    logic [15:0] run_cycles;
    logic [3:0]  activity;
    logic [31:0] seed;
    logic [1:0]  mem_wr;
    logic [63:0] mem_data;
    logic [1:0]  err_detected;
    logic [1:0]  err_corrected;
    logic        busy;
    logic        sync;
    logic        done;
    logic [15:0] det_cnt;
    logic [15:0] cor_cnt;
    logic [1:0]  err_sticky;

    int n_checks = 0;
    int n_fail   = 0;

    mem_traffic_gen dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .mode          (mode),
        .run_cycles    (run_cycles),
        .activity      (activity),
        .seed          (seed),
        .mem_wr        (mem_wr),
        .mem_data      (mem_data),
        .err_detected  (err_detected),
        .err_corrected (err_corrected),
        .busy          (busy),
        .sync          (sync),
        .done          (done),
        .det_cnt       (det_cnt),
        .cor_cnt       (cor_cnt),
        .err_sticky    (err_sticky)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [1:0] m, input logic [15:0] rc,
                             input logic [3:0] act, input logic [31:0] sd);
        mode       = m;
        run_cycles = rc;
        activity   = act;
        seed       = sd;
        start      = 1'b1;
        tick();
        start      = 1'b0;
    endtask

    task automatic wait_done(input int max_cycles, input string tag);
        for (int i = 0; i < max_cycles; i++) begin
            if (done) break;
            tick();
        end
        check_val(tag, done, 1);
    endtask

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return v[0] ? ((v >> 1) ^ 32'h80200003) : (v >> 1);
    endfunction

    initial begin
        logic [31:0] rnd_exp [6];
        logic [31:0] m_lfsr;
        logic [31:0] m_data;
        logic        m_wr;
        int          first_sync;

        rnd_exp = '{32'h00000001, 32'h80200003, 32'hC0300002,
                    32'h60180001, 32'hB02C0003, 32'hD8360002};

        rst_n = 1'b0; start = 1'b0; mode = '0; run_cycles = '0; activity = '0;
        seed = '0; err_detected = '0; err_corrected = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check_val("rst_wr", mem_wr, 0);
        check_val("rst_data", mem_data, 0);
        check_val("rst_flags", {busy, sync, done}, 0);
        check_val("rst_cnts", {det_cnt, cor_cnt, err_sticky}, 0);
        rst_n = 1'b1;
        tick();
        check_val("idle_busy", busy, 0);

        // COUNT, seed 0, 5 cycles
        start_run(c_COUNT, 16'd5, 4'd0, 32'd0);
        for (int k = 0; k < 5; k++) begin
            check_val("cnt_d0", mem_data[31:0], 64'(k));
            check_val("cnt_d1", mem_data[63:32], 64'(32'h9E3779B9 + k));
            check_val("cnt_wr", mem_wr, 2'b11);
            check_val("cnt_busy", busy, 1);
            tick();
        end
        check_val("cnt_done", done, 1);
        check_val("cnt_end_wr", mem_wr, 0);
        check_val("cnt_end_d", mem_data, {32'h9E3779BD, 32'h00000004});
        check_val("cnt_end_busy_sync", {busy, sync}, 2'b01);

        // BYTE_COUNT, 258 cycles
        start_run(c_BYTE, 16'd258, 4'd0, 32'h5555AAAA);
        for (int k = 0; k < 258; k++) begin
            logic [7:0] b;
            b = 8'(k);
            check_val("byte_d", mem_data, {8{b}});
            check_val("byte_wr_busy", {mem_wr, busy}, 3'b111);
            tick();
        end
        check_val("byte_end", {busy, done, mem_wr}, 4'b0100);

        // RANDOM, seed 1, activity 0: channel 0 follows the LFSR from 1
        start_run(c_RANDOM, 16'd6, 4'd0, 32'd1);
        for (int k = 0; k < 6; k++) begin
            check_val("rnd_d0", mem_data[31:0], rnd_exp[k]);
            check_val("rnd_wr0", mem_wr[0], rnd_exp[k][0]);
            tick();
        end
        check_val("rnd_end", {done, mem_wr}, 3'b100);

        // RANDOM, activity 4'hF: sparse updates, hold otherwise
        start_run(c_RANDOM, 16'd64, 4'hF, 32'h12345678);
        m_lfsr = 32'h12345678;
        m_data = m_lfsr;
        m_wr   = m_lfsr[0];
        for (int k = 0; k < 64; k++) begin
            if (k > 0) begin
                m_lfsr = lfsr_step(m_lfsr);
                if (m_lfsr[31:28] == 4'h0) begin
                    m_data = m_lfsr;
                    m_wr   = m_lfsr[0];
                end
            end
            check_val("rndf_d0", mem_data[31:0], m_data);
            check_val("rndf_wr0", mem_wr[0], m_wr);
            tick();
        end
        check_val("rndf_hold", {done, mem_wr, mem_data[31:0]}, {1'b1, 2'b00, m_data});

        // HOLD: no strobes, data fixed at the COUNT init value
        start_run(c_HOLD, 16'd3, 4'd0, 32'h000000AA);
        for (int k = 0; k < 3; k++) begin
            check_val("hold_d", mem_data, {32'h9E377913, 32'h000000AA});
            check_val("hold_wr", mem_wr, 0);
            tick();
        end
        wait_done(10, "hold_done");

        // Error counting: 3 pulses plus one held level on ch1, 2 corrected pulses on ch0
        start_run(c_COUNT, 16'd40, 4'd0, 32'd0);
        for (int p = 0; p < 3; p++) begin
            err_detected[1] = 1'b1; tick();
            err_detected[1] = 1'b0; tick();
        end
        for (int p = 0; p < 2; p++) begin
            err_corrected[0] = 1'b1; tick();
            err_corrected[0] = 1'b0; tick();
        end
        err_detected[1] = 1'b1;
        repeat (3) tick();
        check_val("err_det", det_cnt, {8'd4, 8'd0});
        check_val("err_cor", cor_cnt, {8'd0, 8'd2});
        check_val("err_sticky", err_sticky, 2'b10);
        err_detected[1] = 1'b0;
        wait_done(100, "err_run_done");

        // Saturation: 300 pulses on ch0 (monitor active in DONE)
        for (int p = 0; p < 300; p++) begin
            err_detected[0] = 1'b1; tick();
            err_detected[0] = 1'b0; tick();
        end
        check_val("err_sat", det_cnt, {8'd4, 8'd255});
        check_val("err_sticky2", err_sticky, 2'b11);

        // Rise coincident with an accepted start: start wins
        err_detected[0] = 1'b1;
        start_run(c_COUNT, 16'd3, 4'd0, 32'd0);
        check_val("err_start_det", det_cnt, 0);
        check_val("err_start_cor_st", {cor_cnt, err_sticky}, 0);
        err_detected[0] = 1'b0;
        wait_done(10, "err_start_done");

        // run_cycles = 0 behaves as one cycle
        start_run(c_COUNT, 16'd0, 4'd0, 32'd0);
        check_val("rc0_busy", {busy, done}, 2'b10);
        tick();
        check_val("rc0_done", {busy, done}, 2'b01);

        // run_cycles = 16: sync at elapsed 14, start mid-run ignored
        start_run(c_COUNT, 16'd16, 4'd0, 32'd0);
        first_sync = -1;
        for (int k = 0; k < 16; k++) begin
            if (sync && first_sync < 0) first_sync = k;
            if (k == 5) begin
                mode  = c_RANDOM;
                seed  = 32'hDEADBEEF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
        end
        start = 1'b0;
        check_val("sync_rise", 64'(first_sync), 14);
        check_val("norestart_done", {busy, done}, 2'b01);
        check_val("norestart_d0", mem_data[31:0], 15);

        // Asynchronous reset at RUN cycle 3
        start_run(c_COUNT, 16'd20, 4'd0, 32'd0);
        err_detected[1] = 1'b1; tick();
        err_detected[1] = 1'b0; tick();
        tick();
        check_val("pre_rst", {busy, det_cnt[15:8]}, {1'b1, 8'd1});
        #2 rst_n = 1'b0;
        #1;
        check_val("arst_wr_data", {mem_wr, mem_data}, 0);
        check_val("arst_flags", {busy, sync, done}, 0);
        check_val("arst_cnts", {det_cnt, cor_cnt, err_sticky}, 0);
        #3 rst_n = 1'b1;
        repeat (5) tick();
        check_val("post_rst_idle", {busy, done, mem_wr}, 0);
        check_val("post_rst_data", mem_data, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_traffic_gen.md
Name: mem_traffic_gen

Overview:
Synthesizable, parametrised traffic generator and error monitor for N ECC/CRC-protected memory channels. It replaces cycle-based stimulus with RTL that has selectable modes, drives wr/data per channel for a programmed number of cycles, and counts detected and corrected error events per channel. It sits between the test controller (or fault-injection harness) and the memory DUT's mem*_wr, mem*_data_in and mem*_err_* ports.

Parameters:
NUM_CH, 2, number of memory channels
DATA_W, 32, data width per channel; must be a multiple of 8 and at least 8
CNT_W, 16, width of the run-cycle counter
ACT_W, 4, width of the activity mask; must be 1..16
ERR_W, 8, width of each saturating error counter

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  start a run (sampled in IDLE/DONE only)
mode  in  2  0=COUNT, 1=BYTE_COUNT, 2=RANDOM, 3=HOLD; latched at start
run_cycles  in  CNT_W  run length in cycles; latched at start
activity  in  ACT_W  RANDOM update mask; latched at start
seed  in  32  LFSR/COUNT seed; latched at start
mem_wr  out  NUM_CH  per-channel write strobe
mem_data  out  NUM_CH*DATA_W  per-channel data; channel c at [c*DATA_W +: DATA_W]
err_detected  in  NUM_CH  per-channel error-detected flag from the DUT
err_corrected  in  NUM_CH  per-channel error-corrected flag from the DUT
busy  out  1  high in RUN
sync  out  1  high from the last 1/8 of the run until the next start
done  out  1  high in DONE
det_cnt  out  NUM_CH*ERR_W  rising-edge count of err_detected, saturating
cor_cnt  out  NUM_CH*ERR_W  rising-edge count of err_corrected, saturating
err_sticky  out  NUM_CH  set on any err_detected rise; cleared by start

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0. LFSRs 0. Edge-detect registers 0.
- FSM:
  - IDLE --start--> RUN.
  - RUN --elapsed==max(run_cycles,1)--> DONE.
  - DONE --start--> RUN.
  - start in RUN is ignored.
- On accepted start (same edge):
  - Latch mode, run_cycles, activity and seed.
  - Clear elapsed, det_cnt, cor_cnt, err_sticky, sync and the byte counter.
  - Load the per-channel LFSR with s_c = seed ^ (c*32'h9E3779B9); if s_c==0, load 32'h1.
  - Load mem_data with the mode init value.
- RUN duration: exactly max(run_cycles,1) clock cycles, so run_cycles=0 behaves as 1. elapsed increments each RUN cycle.
- sync is set when elapsed >= run_cycles - (run_cycles>>3) and held until the next start.
- COUNT mode:
  - Init data = s_c replicated/truncated to DATA_W.
  - mem_wr=all 1.
  - data <= data+1 each RUN cycle, mod 2^DATA_W.
  - The first RUN cycle shows the init value.
- BYTE_COUNT mode:
  - data = {DATA_W/8{cnt8}}, with cnt8 starting at 0x00.
  - cnt8 increments each RUN cycle and wraps 0xFF->0x00.
  - mem_wr=all 1.
- RANDOM mode:
  - Each channel steps a 32-bit Galois LFSR (taps 32'h80200003) every RUN cycle.
  - The channel updates when (lfsr[31 -: ACT_W] & activity)==0. activity=0 gives an update every cycle; a mask with k ones gives probability 2^-k.
  - On update: mem_wr[c] <= lfsr[0]; data <= lfsr replicated/truncated to DATA_W.
  - Otherwise wr and data hold.
- HOLD mode: mem_wr=0; data holds its init (COUNT init value).
- Leaving RUN: mem_wr <= 0 on the transition cycle. mem_data holds its last value.
- Error monitoring:
  - Active in every state.
  - A rise is in=1 with the previous-cycle in=0.
  - Each rise increments its counter, saturating at 2^ERR_W-1.
  - A rise on the same edge as an accepted start: start wins, and the counter becomes 0.
  - err_sticky[c] is set by an err_detected[c] rise.
- Async reset mid-run: immediate return to IDLE with all outputs 0. No run resumes without a new start.

Test Plan:
1. COUNT: NUM_CH=2, DATA_W=32, seed=0, run_cycles=5 -> ch0 data 0,1,2,3,4 with wr=1; ch1 data 9E3779B9..9E3779BD; then done=1, wr=0, data held at 4 and 9E3779BD.
2. BYTE_COUNT: run_cycles=258 -> data 00000000,01010101,...,FFFFFFFF,00000000,01010101; wr=1 throughout; busy high for exactly 258 cycles.
3. RANDOM: seed=1, activity=0 -> ch0 data matches the LFSR sequence from 32'h1 every cycle. With activity=4'hF, about 1/16 of cycles update and data holds otherwise.
4. Errors: 3 pulses on err_detected[1] plus one held level during the run -> det_cnt ch1=4, err_sticky=2'b10. 300 pulses -> saturates at 255. A pulse coincident with start -> 0.
5. Boundaries: run_cycles=0 -> exactly 1 RUN cycle. run_cycles=16 -> sync rises at elapsed=14. start during RUN -> no restart.
6. Reset: rst_n low at cycle 3 of RUN -> all outputs 0 asynchronously; after release the FSM stays IDLE until start.
